axi_rd_arbiter: RTL and testbench

//  Round-robin arbiter sharing one AXI read path (AR + R) among MasterCount masters.
//  - Grants one master at a time and routes its AR handshake to the slave side.
//  - Holds the grant until the R burst ending with RLAST completes for that master's ID.
//  - Sits ahead of the S2M by-ID decoder, which steers R beats back by RID == master index.
//  - Single outstanding read; a watchdog aborts hung bursts.

---
 rtl/axi_rd_arbiter.sv | 137 +++++++++++++
 tb/tb_axi_rd_arbiter.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read path (AR + R) among masters.
// Holds each grant from the AR handshake until RLAST or a watchdog abort.
module axi_rd_arbiter #(
    parameter int MasterCount = 2,
    parameter int TIMEOUT     = 255,
    parameter int SELW        = 1
) (
    input  logic                   ACLK,
    input  logic                   ARESET,
    input  logic [MasterCount-1:0] ARVALID_M,
    output logic [MasterCount-1:0] ARREADY_M,
    output logic                   ARVALID_S,
    input  logic                   ARREADY_S,
    input  logic                   RVALID_S,
    input  logic                   RREADY_S,
    input  logic                   RLAST_S,
    input  logic [3:0]             RID_S,
    output logic [SELW-1:0]        ar_sel,
    output logic                   busy,
    output logic [7:0]             beat_cnt,
    output logic                   timeout_err
);

    localparam int IW = SELW + 1;

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t          state;
    state_t          state_nx;
    logic [SELW-1:0] ptr;
    logic [SELW-1:0] ptr_nx;
    logic [SELW-1:0] sel_nx;
    logic [SELW-1:0] sel_inc;
    logic [SELW-1:0] win;
    logic            found;
    logic [IW-1:0]   idx;
    logic [7:0]      cnt_nx;
    logic [15:0]     wdog;
    logic [15:0]     wdog_nx;
    logic [3:0]      sel4;
    logic            beat;

    assign sel4 = 4'(ar_sel);
    assign beat = RVALID_S & RREADY_S & (RID_S == sel4);
    assign busy = (state != IDLE);

    assign sel_inc = (ar_sel == SELW'(MasterCount - 1))
                   ? '0 : ar_sel + 1'b1;

    // First requester found scanning upward from ptr, modulo MasterCount
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < MasterCount; i++) begin
            idx = {1'b0, ptr} + IW'(i);
            if (idx >= IW'(MasterCount)) begin
                idx = idx - IW'(MasterCount);
            end
            if (!found && ARVALID_M[idx[SELW-1:0]]) begin
                found = 1'b1;
                win   = idx[SELW-1:0];
            end
        end
    end

    always_comb begin
        state_nx    = state;
        ptr_nx      = ptr;
        sel_nx      = ar_sel;
        cnt_nx      = beat_cnt;
        wdog_nx     = wdog;
        ARVALID_S   = 1'b0;
        ARREADY_M   = '0;
        timeout_err = 1'b0;
        unique case (state)
            IDLE: begin
                if (found) begin
                    sel_nx   = win;
                    state_nx = ADDR;
                end
            end
            ADDR: begin
                ARVALID_S         = ARVALID_M[ar_sel];
                ARREADY_M[ar_sel] = ARREADY_S;
                if (ARVALID_M[ar_sel] && ARREADY_S) begin
                    state_nx = DATA;
                    cnt_nx   = '0;
                    wdog_nx  = '0;
                end
            end
            DATA: begin
                if (beat) begin
                    if (beat_cnt != 8'hff) begin
                        cnt_nx = beat_cnt + 8'd1;
                    end
                    wdog_nx = '0;
                    if (RLAST_S) begin
                        state_nx = IDLE;
                        ptr_nx   = sel_inc;
                    end
                end else if (wdog == 16'(TIMEOUT - 1)) begin
                    // Hung burst: abandon it and rotate as if completed
                    timeout_err = 1'b1;
                    state_nx    = IDLE;
                    ptr_nx      = sel_inc;
                end else begin
                    wdog_nx = wdog + 16'd1;
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state    <= IDLE;
            ptr      <= '0;
            ar_sel   <= '0;
            beat_cnt <= '0;
            wdog     <= '0;
        end else begin
            state    <= state_nx;
            ptr      <= ptr_nx;
            ar_sel   <= sel_nx;
            beat_cnt <= cnt_nx;
            wdog     <= wdog_nx;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Randomised bench for axi_rd_arbiter against a transaction-level model.
// Three masters so the round-robin pointer wraps at a non-power-of-two.
module tb_axi_rd_arbiter;

    localparam int MC   = 3;
    localparam int TO   = 8;
    localparam int SELW = 2;

    logic          clk = 1'b0;
    logic          ARESET;
    logic [MC-1:0] ARVALID_M;
    logic [MC-1:0] ARREADY_M;
    logic          ARVALID_S;
    logic          ARREADY_S;
    logic          RVALID_S;
    logic          RREADY_S;
    logic          RLAST_S;
    logic [3:0]    RID_S;
    logic [SELW-1:0] ar_sel;
    logic          busy;
    logic [7:0]    beat_cnt;
    logic          timeout_err;

    int errors = 0;
    int checks = 0;

    // Model: phase 0 idle, 1 address offered, 2 burst in progress
    int m_phase;
    int m_ptr;
    int m_sel;
    int m_cnt;
    int m_idle;

    axi_rd_arbiter #(
        .MasterCount(MC),
        .TIMEOUT    (TO),
        .SELW       (SELW)
    ) dut (
        .ACLK       (clk),
        .ARESET     (ARESET),
        .ARVALID_M  (ARVALID_M),
        .ARREADY_M  (ARREADY_M),
        .ARVALID_S  (ARVALID_S),
        .ARREADY_S  (ARREADY_S),
        .RVALID_S   (RVALID_S),
        .RREADY_S   (RREADY_S),
        .RLAST_S    (RLAST_S),
        .RID_S      (RID_S),
        .ar_sel     (ar_sel),
        .busy       (busy),
        .beat_cnt   (beat_cnt),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_ptr   = 0;
        m_sel   = 0;
        m_cnt   = 0;
        m_idle  = 0;
    endtask

    // Compare at the falling edge, then advance the model to the next rise
    task automatic tick();
        bit          hit;
        bit          tmo;
        int          j;
        logic [MC-1:0] exp_rdy;
        @(negedge clk);
        hit = RVALID_S && RREADY_S && (int'(RID_S) == m_sel);
        tmo = (m_phase == 2) && !hit && (m_idle == TO - 1);
        exp_rdy = '0;
        if (m_phase == 1 && ARREADY_S) exp_rdy[m_sel] = 1'b1;
        chk("busy", 32'(busy), 32'(m_phase != 0));
        chk("ar_sel", 32'(ar_sel), 32'(m_sel));
        chk("beat_cnt", 32'(beat_cnt), 32'(m_cnt));
        chk("arvalid_s", 32'(ARVALID_S),
            32'(m_phase == 1 && ARVALID_M[m_sel]));
        chk("arready_m", 32'(ARREADY_M), 32'(exp_rdy));
        chk("timeout_err", 32'(timeout_err), 32'(tmo));
        if (m_phase == 0) begin
            for (int k = 0; k < MC; k++) begin
                j = (m_ptr + k) % MC;
                if (m_phase == 0 && ARVALID_M[j]) begin
                    m_sel   = j;
                    m_phase = 1;
                end
            end
        end else if (m_phase == 1) begin
            if (ARVALID_M[m_sel] && ARREADY_S) begin
                m_phase = 2;
                m_cnt   = 0;
                m_idle  = 0;
            end
        end else begin
            if (hit) begin
                m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
                m_idle = 0;
                if (RLAST_S) begin
                    m_phase = 0;
                    m_ptr   = (m_sel + 1) % MC;
                end
            end else if (tmo) begin
                m_phase = 0;
                m_ptr   = (m_sel + 1) % MC;
            end else begin
                m_idle++;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic r_idle();
        RVALID_S = 1'b0;
        RREADY_S = 1'b0;
        RLAST_S  = 1'b0;
        RID_S    = '0;
    endtask

    initial begin
        int mode;
        ARESET    = 1'b1;
        ARVALID_M = '0;
        ARREADY_S = 1'b0;
        r_idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        ARESET = 1'b0;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_cnt", 32'(beat_cnt), 32'd0);
        chk("rst_sel", 32'(ar_sel), 32'd0);

        // Lone master 0, four-beat burst
        ARVALID_M = 3'b001;
        ARREADY_S = 1'b1;
        tick();
        chk("t1_arvalid", 32'(ARVALID_S), 32'd1);
        chk("t1_sel", 32'(ar_sel), 32'd0);
        tick();
        ARVALID_M = '0;
        RVALID_S  = 1'b1;
        RREADY_S  = 1'b1;
        RID_S     = 4'd0;
        repeat (3) tick();
        RLAST_S = 1'b1;
        tick();
        chk("t1_cnt", 32'(beat_cnt), 32'd4);
        chk("t1_idle", 32'(busy), 32'd0);

        // Pointer now 1: master 1 wins over master 0
        r_idle();
        ARVALID_M = 3'b011;
        tick();
        chk("rr_sel", 32'(ar_sel), 32'd1);
        tick();
        ARVALID_M = '0;
        RVALID_S  = 1'b1;
        RREADY_S  = 1'b1;
        RID_S     = 4'd1;
        RLAST_S   = 1'b1;
        tick();
        r_idle();

        // Watchdog: pointer 2 scans to master 0, no R beats
        ARVALID_M = 3'b001;
        tick();
        tick();
        ARVALID_M = '0;
        repeat (7) tick();
        chk("wd_pulse", 32'(timeout_err), 32'd1);
        tick();
        chk("wd_idle", 32'(busy), 32'd0);
        chk("wd_clear", 32'(timeout_err), 32'd0);

        for (int c = 0; c < 3000; c++) begin
            mode = (c / 200) % 3;
            ARVALID_M = MC'($urandom);
            ARREADY_S = ($urandom_range(0, 1) == 1);
            if (mode == 0) begin
                RVALID_S = ($urandom_range(0, 1) == 1);
                RREADY_S = ($urandom_range(0, 9) < 7);
                RID_S    = ($urandom_range(0, 9) < 6)
                         ? 4'(m_sel) : 4'($urandom);
                RLAST_S  = ($urandom_range(0, 3) == 0);
            end else if (mode == 1) begin
                r_idle();
                RID_S = 4'(m_sel);
            end else begin
                RVALID_S = 1'b1;
                RREADY_S = 1'b1;
                RID_S    = 4'(m_sel);
                RLAST_S  = 1'b0;
            end
            if (c == 450) begin
                ARESET = 1'b1;
                #1;
                chk("ar_busy", 32'(busy), 32'd0);
                chk("ar_cnt", 32'(beat_cnt), 32'd0);
                chk("ar_sel", 32'(ar_sel), 32'd0);
                chk("ar_arv", 32'(ARVALID_S), 32'd0);
                chk("ar_rdy", 32'(ARREADY_M), 32'd0);
                chk("ar_tmo", 32'(timeout_err), 32'd0);
                #1;
                ARESET = 1'b0;
                model_reset();
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
